pu_riscv_alu_pipe: RTL and testbench

- Parametrised, pipelined integer ALU for the execute stage; next generation of the single-cycle core ALU.
- Takes pre-decoded operations with a valid/ready handshake on both sides, supports backpressure and pipeline flush, and carries a tag for the writeback destination.
- Adds RV64 W-variants for every arithmetic and shift op, plus a Zbb subset: andn, orn, xnor, min/max, rotates, clz, ctz and cpop.
- Latency is configurable from 1 to 3 cycles so timing can be closed at higher clock rates.

---
 rtl/pu_riscv_alu_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_pu_riscv_alu_pipe.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_riscv_alu_pipe.sv
// Pipelined execute-stage integer ALU: RV64I arithmetic/logic, W-variants and a Zbb subset,
// with valid/ready handshakes, flush, a pass-through tag and 1..3 cycles of latency.
module pu_riscv_alu_pipe #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STAGES = 1,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic             in_word,
  input  logic             in_rvc,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_ANDN = 5'd10;
  localparam logic [4:0] OP_ORN  = 5'd11;
  localparam logic [4:0] OP_XNOR = 5'd12;
  localparam logic [4:0] OP_MIN  = 5'd13;
  localparam logic [4:0] OP_MAX  = 5'd14;
  localparam logic [4:0] OP_MINU = 5'd15;
  localparam logic [4:0] OP_MAXU = 5'd16;
  localparam logic [4:0] OP_ROL  = 5'd17;
  localparam logic [4:0] OP_ROR  = 5'd18;
  localparam logic [4:0] OP_CLZ  = 5'd19;
  localparam logic [4:0] OP_CTZ  = 5'd20;
  localparam logic [4:0] OP_CPOP = 5'd21;
  localparam logic [4:0] OP_PASB = 5'd22;
  localparam logic [4:0] OP_LINK = 5'd23;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic [XLEN-1:0] r;
    r       = {XLEN{x[31]}};
    r[31:0] = x;
    return r;
  endfunction

  // Count functions take the effective width so W mode reuses them on a zero-extended operand.
  function automatic logic [6:0] clz_f(input logic [XLEN-1:0] x, input int w);
    logic [6:0] n;
    n = 7'(w);
    for (int i = 0; i < int'(XLEN); i++)
      if (i < w && x[i]) n = 7'(w - 1 - i);
    return n;
  endfunction

  function automatic logic [6:0] ctz_f(input logic [XLEN-1:0] x, input int w);
    logic [6:0] n;
    n = 7'(w);
    for (int i = int'(XLEN) - 1; i >= 0; i--)
      if (i < w && x[i]) n = 7'(i);
    return n;
  endfunction

  function automatic logic [6:0] cpop_f(input logic [XLEN-1:0] x);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < int'(XLEN); i++) n = n + 7'(x[i]);
    return n;
  endfunction

  logic            word_c;
  logic [SHW-1:0]  sh_c;
  logic [4:0]      sh5_c;
  logic [31:0]     a32_c;
  logic [31:0]     b32_c;
  logic [XLEN-1:0] a32x_c;
  logic [XLEN-1:0] rol_c;
  logic [XLEN-1:0] ror_c;
  logic [31:0]     rol32_c;
  logic [31:0]     ror32_c;
  logic            lt_c;
  logic            ltu_c;
  logic [XLEN-1:0] res_c;
  logic            err_c;

  assign word_c  = in_word & (XLEN == 64);
  assign sh_c    = in_b[SHW-1:0];
  assign sh5_c   = in_b[4:0];
  assign a32_c   = in_a[31:0];
  assign b32_c   = in_b[31:0];
  assign a32x_c  = XLEN'(a32_c);
  assign rol_c   = XLEN'(({in_a, in_a} << sh_c) >> XLEN);
  assign ror_c   = XLEN'({in_a, in_a} >> sh_c);
  assign rol32_c = 32'(({a32_c, a32_c} << sh5_c) >> 32);
  assign ror32_c = 32'({a32_c, a32_c} >> sh5_c);
  assign lt_c    = $signed(in_a) < $signed(in_b);
  assign ltu_c   = in_a < in_b;

  // Result datapath, captured into stage 1 on accept.
  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    case (in_op)
      OP_ADD:  res_c = word_c ? sext32(a32_c + b32_c) : in_a + in_b;
      OP_SUB:  res_c = word_c ? sext32(a32_c - b32_c) : in_a - in_b;
      OP_SLL:  res_c = word_c ? sext32(a32_c << sh5_c) : in_a << sh_c;
      OP_SLT:  res_c = XLEN'(lt_c);
      OP_SLTU: res_c = XLEN'(ltu_c);
      OP_XOR:  res_c = in_a ^ in_b;
      OP_SRL:  res_c = word_c ? sext32(a32_c >> sh5_c) : in_a >> sh_c;
      OP_SRA:  res_c = word_c ? sext32(32'($signed(a32_c) >>> sh5_c))
                              : XLEN'($signed(in_a) >>> sh_c);
      OP_OR:   res_c = in_a | in_b;
      OP_AND:  res_c = in_a & in_b;
      OP_ANDN: res_c = in_a & ~in_b;
      OP_ORN:  res_c = in_a | ~in_b;
      OP_XNOR: res_c = ~(in_a ^ in_b);
      OP_MIN:  res_c = lt_c ? in_a : in_b;
      OP_MAX:  res_c = lt_c ? in_b : in_a;
      OP_MINU: res_c = ltu_c ? in_a : in_b;
      OP_MAXU: res_c = ltu_c ? in_b : in_a;
      OP_ROL:  res_c = word_c ? sext32(rol32_c) : rol_c;
      OP_ROR:  res_c = word_c ? sext32(ror32_c) : ror_c;
      OP_CLZ:  res_c = word_c ? XLEN'(clz_f(a32x_c, 32)) : XLEN'(clz_f(in_a, int'(XLEN)));
      OP_CTZ:  res_c = word_c ? XLEN'(ctz_f(a32x_c, 32)) : XLEN'(ctz_f(in_a, int'(XLEN)));
      OP_CPOP: res_c = word_c ? XLEN'(cpop_f(a32x_c)) : XLEN'(cpop_f(in_a));
      OP_PASB: res_c = in_b;
      OP_LINK: res_c = in_pc + (in_rvc ? XLEN'(2) : XLEN'(4));
      default: err_c = 1'b1;
    endcase
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] err_q;
  logic [STAGES-1:0] err_d;
  logic [STAGES-1:0] adv_c;
  logic [XLEN-1:0]   res_q [STAGES];
  logic [XLEN-1:0]   res_d [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];

  // A stage advances if it or any later stage is empty, or the consumer takes the result.
  always_comb begin
    adv_c = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      adv_c[i] = out_ready;
      for (int j = i; j < int'(STAGES); j++)
        if (!v_q[j]) adv_c[i] = 1'b1;
    end
  end

  always_comb begin
    v_d   = v_q;
    err_d = err_q;
    res_d = res_q;
    tag_d = tag_q;
    if (adv_c[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        res_d[0] = res_c;
        err_d[0] = err_c;
        tag_d[0] = in_tag;
      end
    end
    for (int i = 1; i < int'(STAGES); i++) begin
      if (adv_c[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          res_d[i] = res_q[i-1];
          err_d[i] = err_q[i-1];
          tag_d[i] = tag_q[i-1];
        end
      end
    end
    if (flush) v_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q   <= '0;
      err_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      err_q <= err_d;
      for (int i = 0; i < int'(STAGES); i++) begin
        res_q[i] <= res_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign in_ready   = adv_c[0];
  assign out_valid  = v_q[STAGES-1];
  assign out_result = res_q[STAGES-1];
  assign out_tag    = tag_q[STAGES-1];
  assign out_err    = err_q[STAGES-1];

endmodule

// File: tb/tb_pu_riscv_alu_pipe.sv
// Bench for pu_riscv_alu_pipe: a 1-stage and a 3-stage instance share one input bus;
// directed vectors, latency/backpressure/flush/reset sequences and a randomized scoreboard run.
module tb_pu_riscv_alu_pipe;

  typedef struct {
    logic [4:0]  op;
    logic        word;
    logic        rvc;
    logic [63:0] pc;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        err;
    logic [4:0]  tag;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic [4:0]  in_op;
  logic        in_word;
  logic        in_rvc;
  logic [63:0] in_pc;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [4:0]  in_tag;

  logic        in_ready1, out_valid1, out_ready1, out_err1;
  logic [63:0] out_result1;
  logic [4:0]  out_tag1;
  logic        in_ready3, out_valid3, out_ready3, out_err3;
  logic [63:0] out_result3;
  logic [4:0]  out_tag3;

  int checks;
  int failures;
  vec_t vecs[$];
  exp_t q1[$];
  exp_t q3[$];

  pu_riscv_alu_pipe #(.XLEN(64), .STAGES(1), .TAG_W(5)) dut1 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_word(in_word), .in_rvc(in_rvc), .in_pc(in_pc), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .out_valid(out_valid1), .out_ready(out_ready1), .out_result(out_result1),
    .out_tag(out_tag1), .out_err(out_err1)
  );

  pu_riscv_alu_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5)) dut3 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .in_op(in_op), .in_word(in_word), .in_rvc(in_rvc), .in_pc(in_pc), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .out_valid(out_valid3), .out_ready(out_ready3), .out_result(out_result3),
    .out_tag(out_tag3), .out_err(out_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Reference model: each op evaluated straight from its arithmetic definition.
  function automatic logic [64:0] ref_alu(input logic [4:0] op, input logic word, input logic rvc,
                                          input logic [63:0] pc, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] r;
    logic [31:0] x;
    logic [31:0] t;
    logic        e;
    int          s;
    int          n;
    e = 1'b0;
    r = '0;
    if (word && (op inside {0, 1, 2, 6, 7, 17, 18, 19, 20, 21})) begin
      x = a[31:0];
      s = int'(b[4:0]);
      t = '0;
      case (op)
        0:  t = x + b[31:0];
        1:  t = x - b[31:0];
        2:  t = x << s;
        6:  t = x >> s;
        7:  t = $signed(x) >>> s;
        17: begin t = x; repeat (s) t = {t[30:0], t[31]}; end
        18: begin t = x; repeat (s) t = {t[0], t[31:1]}; end
        19: begin n = 0; while (n < 32 && !x[31-n]) n++; t = 32'(n); end
        20: begin n = 0; while (n < 32 && !x[n]) n++; t = 32'(n); end
        default: t = 32'($countones(x));
      endcase
      r = {{32{t[31]}}, t};
    end else begin
      s = int'(b[5:0]);
      case (op)
        0:  r = a + b;
        1:  r = a - b;
        2:  r = a << s;
        3:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        4:  r = (a < b) ? 64'd1 : 64'd0;
        5:  r = a ^ b;
        6:  r = a >> s;
        7:  r = $signed(a) >>> s;
        8:  r = a | b;
        9:  r = a & b;
        10: r = a & ~b;
        11: r = a | ~b;
        12: r = ~(a ^ b);
        13: r = ($signed(a) < $signed(b)) ? a : b;
        14: r = ($signed(a) > $signed(b)) ? a : b;
        15: r = (a < b) ? a : b;
        16: r = (a > b) ? a : b;
        17: begin r = a; repeat (s) r = {r[62:0], r[63]}; end
        18: begin r = a; repeat (s) r = {r[0], r[63:1]}; end
        19: begin n = 0; while (n < 64 && !a[63-n]) n++; r = 64'(n); end
        20: begin n = 0; while (n < 64 && !a[n]) n++; r = 64'(n); end
        21: r = 64'($countones(a));
        22: r = b;
        23: r = pc + (rvc ? 64'd2 : 64'd4);
        default: e = 1'b1;
      endcase
    end
    return {e, r};
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom % 7)
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom % 70);
      4: return {32'd0, 32'($urandom)};
      5: return {32'hFFFF_FFFF, 32'($urandom)};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drive(input logic [4:0] op, input logic word, input logic rvc,
                       input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag);
    in_valid = 1'b1;
    in_op = op; in_word = word; in_rvc = rvc; in_pc = pc; in_a = a; in_b = b; in_tag = tag;
  endtask

  task automatic pop_chk1();
    exp_t e;
    if (q1.size() == 0) begin
      checks++; failures++;
      $display("FAIL rnd1_unexpected: got out_valid with tag %0d expected no result", out_tag1);
    end else begin
      e = q1.pop_front();
      chk("rnd1_result", out_result1, e.res);
      chk("rnd1_err", 64'(out_err1), 64'(e.err));
      chk("rnd1_tag", 64'(out_tag1), 64'(e.tag));
    end
  endtask

  task automatic pop_chk3();
    exp_t e;
    if (q3.size() == 0) begin
      checks++; failures++;
      $display("FAIL rnd3_unexpected: got out_valid with tag %0d expected no result", out_tag3);
    end else begin
      e = q3.pop_front();
      chk("rnd3_result", out_result3, e.res);
      chk("rnd3_err", 64'(out_err3), 64'(e.err));
      chk("rnd3_tag", 64'(out_tag3), 64'(e.tag));
    end
  endtask

  // One random cycle: inputs set at negedge, handshakes evaluated before the next posedge.
  task automatic rand_cycle(input bit new_ops);
    logic [64:0] m;
    exp_t        e;
    flush      = new_ops && ($urandom % 30 == 0);
    in_valid   = new_ops && ($urandom % 4 != 0);
    in_op      = ($urandom % 10 == 0) ? 5'(24 + $urandom % 8) : 5'($urandom % 24);
    in_word    = 1'($urandom);
    in_rvc     = 1'($urandom);
    in_pc      = rnd64();
    in_a       = rnd64();
    in_b       = rnd64();
    in_tag     = 5'($urandom);
    out_ready1 = !new_ops || ($urandom % 4 != 0);
    out_ready3 = !new_ops || ($urandom % 3 != 0);
    if (flush) begin out_ready1 = 1'b0; out_ready3 = 1'b0; end
    #1;
    m = ref_alu(in_op, in_word, in_rvc, in_pc, in_a, in_b);
    e.res = m[63:0]; e.err = m[64]; e.tag = in_tag;
    if (out_valid1 && out_ready1) pop_chk1();
    if (out_valid3 && out_ready3) pop_chk3();
    if (flush) begin
      q1.delete();
      q3.delete();
    end else begin
      if (in_valid && in_ready1) q1.push_back(e);
      if (in_valid && in_ready3) q3.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_op = '0; in_word = 1'b0; in_rvc = 1'b0; in_pc = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready1 = 1'b1; out_ready3 = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid1", 64'(out_valid1), 64'd0);
    chk("rst_result1", out_result1, 64'd0);
    chk("rst_tag1", 64'(out_tag1), 64'd0);
    chk("rst_err1", 64'(out_err1), 64'd0);
    chk("rst_valid3", 64'(out_valid3), 64'd0);
    chk("rst_result3", out_result3, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready1", 64'(in_ready1), 64'd1);
    chk("rst_in_ready3", 64'(in_ready3), 64'd1);

    // Directed vectors on the 1-stage instance
    vecs.push_back('{5'd0,  1'b1, 1'b0, 64'h0, 64'h7FFF_FFFF, 64'h1, 64'hFFFF_FFFF_8000_0000, 1'b0});
    vecs.push_back('{5'd0,  1'b0, 1'b0, 64'h0, 64'h7FFF_FFFF, 64'h1, 64'h0000_0000_8000_0000, 1'b0});
    vecs.push_back('{5'd7,  1'b0, 1'b0, 64'h0, 64'h8000_0000_0000_0000, 64'd63, '1, 1'b0});
    vecs.push_back('{5'd18, 1'b0, 1'b0, 64'h0, 64'h1, 64'h1, 64'h8000_0000_0000_0000, 1'b0});
    vecs.push_back('{5'd19, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'd64, 1'b0});
    vecs.push_back('{5'd19, 1'b1, 1'b0, 64'h0, 64'h1_0000_0000, 64'h0, 64'd32, 1'b0});
    vecs.push_back('{5'd21, 1'b0, 1'b0, 64'h0, 64'hFF, 64'h0, 64'd8, 1'b0});
    vecs.push_back('{5'd13, 1'b0, 1'b0, 64'h0, '1, 64'h1, '1, 1'b0});
    vecs.push_back('{5'd15, 1'b0, 1'b0, 64'h0, '1, 64'h1, 64'h1, 1'b0});
    vecs.push_back('{5'd3,  1'b0, 1'b0, 64'h0, '1, 64'h1, 64'h1, 1'b0});
    vecs.push_back('{5'd23, 1'b0, 1'b1, 64'h1000, 64'h0, 64'h0, 64'h1002, 1'b0});
    vecs.push_back('{5'd27, 1'b0, 1'b0, 64'h0, 64'h55, 64'h66, 64'h0, 1'b1});
    vecs.push_back('{5'd20, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 64'd32, 1'b0});
    vecs.push_back('{5'd21, 1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_0000_000F, 64'h0, 64'd4, 1'b0});
    vecs.push_back('{5'd2,  1'b0, 1'b0, 64'h0, 64'h1, 64'h41, 64'h2, 1'b0});
    vecs.push_back('{5'd1,  1'b1, 1'b0, 64'h0, 64'h0, 64'h1, '1, 1'b0});
    vecs.push_back('{5'd6,  1'b1, 1'b0, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0800_0000, 1'b0});
    vecs.push_back('{5'd2,  1'b1, 1'b0, 64'h0, 64'h1, 64'd31, 64'hFFFF_FFFF_8000_0000, 1'b0});
    vecs.push_back('{5'd7,  1'b1, 1'b0, 64'h0, 64'h8000_0000, 64'd31, '1, 1'b0});
    vecs.push_back('{5'd18, 1'b1, 1'b0, 64'h0, 64'h1, 64'h1, 64'hFFFF_FFFF_8000_0000, 1'b0});
    vecs.push_back('{5'd17, 1'b0, 1'b0, 64'h0, 64'h8000_0000_0000_0000, 64'h1, 64'h1, 1'b0});
    vecs.push_back('{5'd10, 1'b0, 1'b0, 64'h0, 64'hF0, 64'h30, 64'hC0, 1'b0});
    vecs.push_back('{5'd12, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, '1, 1'b0});
    vecs.push_back('{5'd14, 1'b0, 1'b0, 64'h0, '1, 64'h1, 64'h1, 1'b0});
    vecs.push_back('{5'd16, 1'b0, 1'b0, 64'h0, '1, 64'h1, '1, 1'b0});
    vecs.push_back('{5'd4,  1'b0, 1'b0, 64'h0, '1, 64'h1, 64'h0, 1'b0});
    vecs.push_back('{5'd5,  1'b1, 1'b0, 64'h0, 64'hFFFF_0000_0000_0000, 64'h0, 64'hFFFF_0000_0000_0000, 1'b0});
    vecs.push_back('{5'd22, 1'b0, 1'b0, 64'h0, 64'h0, 64'h1234, 64'h1234, 1'b0});
    vecs.push_back('{5'd23, 1'b0, 1'b0, 64'h1000, 64'h0, 64'h0, 64'h1004, 1'b0});
    vecs.push_back('{5'd19, 1'b0, 1'b0, 64'h0, 64'h1, 64'h0, 64'd63, 1'b0});
    out_ready1 = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].word, vecs[i].rvc, vecs[i].pc, vecs[i].a, vecs[i].b, 5'(i));
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid1), 64'd1);
      chk($sformatf("vec%0d_result", i), out_result1, vecs[i].res);
      chk($sformatf("vec%0d_err", i), 64'(out_err1), 64'(vecs[i].err));
      chk($sformatf("vec%0d_tag", i), 64'(out_tag1), 64'(i));
    end
    in_valid = 1'b0;

    // 3-stage streaming: first result after the third edge, then one tag per cycle
    do_reset();
    out_ready3 = 1'b1;
    drive(5'd0, 1'b0, 1'b0, 64'h0, 64'd0, 64'd1000, 5'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("stream_valid%0d", i), 64'(out_valid3), 64'(i >= 2));
      if (i >= 2) begin
        chk($sformatf("stream_tag%0d", i), 64'(out_tag3), 64'(i - 2));
        chk($sformatf("stream_res%0d", i), out_result3, 64'(1000 + i - 2));
      end
      if (i + 1 < 10) drive(5'd0, 1'b0, 1'b0, 64'h0, 64'(i + 1), 64'd1000, 5'(i + 1));
      else in_valid = 1'b0;
    end

    // Backpressure: three fill the pipe, the fourth is refused, then ordered drain
    do_reset();
    out_ready3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(5'd0, 1'b0, 1'b0, 64'h0, 64'(k), 64'd100, 5'(20 + k));
      #1;
      chk($sformatf("bp_in_ready%0d", k), 64'(in_ready3), 64'(k < 3));
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("bp_stall_valid", 64'(out_valid3), 64'd1);
      chk("bp_stall_tag", 64'(out_tag3), 64'd20);
      chk("bp_stall_result", out_result3, 64'd100);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_drain_valid%0d", k), 64'(out_valid3), 64'd1);
      chk($sformatf("bp_drain_tag%0d", k), 64'(out_tag3), 64'(20 + k));
      chk($sformatf("bp_drain_res%0d", k), out_result3, 64'(100 + k));
      out_ready3 = 1'b1;
      @(negedge clk);
    end
    chk("bp_drain_empty", 64'(out_valid3), 64'd0);

    // Flush of a full pipe, then flush of an input the pipe would have accepted
    do_reset();
    out_ready3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(5'd0, 1'b0, 1'b0, 64'h0, 64'(k), 64'd7, 5'(k + 1));
    end
    @(negedge clk);
    drive(5'd0, 1'b0, 1'b0, 64'h0, 64'd9, 64'd9, 5'd4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid3), 64'd0);
    chk("flush_in_ready", 64'(in_ready3), 64'd1);
    out_ready3 = 1'b1;
    drive(5'd0, 1'b0, 1'b0, 64'h0, 64'd5, 64'd5, 5'd5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("flush_quiet%0d", k), 64'(out_valid3), 64'd0);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream clears outputs without a clock edge
    do_reset();
    out_ready1 = 1'b0;
    out_ready3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(5'd0, 1'b0, 1'b0, 64'h0, 64'd5, 64'd6, 5'(7 + k));
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("arst_pre_valid3", 64'(out_valid3), 64'd1);
    chk("arst_pre_tag3", 64'(out_tag3), 64'd7);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid3", 64'(out_valid3), 64'd0);
    chk("arst_result3", out_result3, 64'd0);
    chk("arst_tag3", 64'(out_tag3), 64'd0);
    chk("arst_valid1", 64'(out_valid1), 64'd0);
    chk("arst_result1", out_result1, 64'd0);
    chk("arst_tag1", 64'(out_tag1), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic against the reference model, then a bounded drain
    do_reset();
    @(negedge clk);
    q1.delete();
    q3.delete();
    for (int c = 0; c < 600; c++) rand_cycle(1'b1);
    for (int c = 0; c < 10; c++) rand_cycle(1'b0);
    chk("rnd1_drained", 64'(q1.size()), 64'd0);
    chk("rnd3_drained", 64'(q3.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
